// File: rtl/id_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_stage_pkg
// Shared definitions for the instruction-decode stage: default widths, the
// opcode/funct encodings the stage recognises, the HALT opcode, and a helper
// that classifies an instruction by the kind of control transfer it performs.
// -----------------------------------------------------------------------------
package id_stage_pkg;

    localparam int BUS_SIZE_DEF = 32;
    localparam int REGS_DEF     = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FUNCT_JR   = 6'b001000;
    localparam logic [5:0] FUNCT_JALR = 6'b001001;

    // Control-transfer class of the instruction sitting in ID.
    typedef enum logic [2:0] {
        JK_NONE = 3'd0,   // not a jump or branch
        JK_ABS  = 3'd1,   // J / JAL: pseudo-absolute target
        JK_REG  = 3'd2,   // JR / JALR: target is rs
        JK_BEQ  = 3'd3,
        JK_BNE  = 3'd4
    } jump_kind_t;

    function automatic jump_kind_t decode_jump_kind(input logic [5:0] op,
                                                    input logic [5:0] funct);
        jump_kind_t kind;
        kind = JK_NONE;
        case (op)
            OP_J, OP_JAL: kind = JK_ABS;
            OP_BEQ:       kind = JK_BEQ;
            OP_BNE:       kind = JK_BNE;
            OP_RTYPE:     if (funct == FUNCT_JR || funct == FUNCT_JALR) kind = JK_REG;
            default:      kind = JK_NONE;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/register_bank.sv
// -----------------------------------------------------------------------------
// register_bank
// REGS x BUS_SIZE general-purpose register file with one write port, two
// combinational read ports and a combinational debug read port.
//   i_clk, i_reset        clock, asynchronous active-high reset (clears all)
//   i_wr_en/addr/data     write port; writes to address 0 are dropped
//   i_rd_addr_a/b, o_rd_data_a/b   operand read ports
//   i_dbg_addr, o_dbg_data         debug read port
// Register 0 always reads 0. A read of the address being written in the same
// cycle returns the incoming write data, so the ID stage sees a value written
// back by WB without waiting an extra cycle.
// -----------------------------------------------------------------------------
module register_bank
    import id_stage_pkg::*;
#(
    parameter int BUS_SIZE = BUS_SIZE_DEF,
    parameter int REGS     = REGS_DEF
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_wr_en,
    input  logic [4:0]          i_wr_addr,
    input  logic [BUS_SIZE-1:0] i_wr_data,
    input  logic [4:0]          i_rd_addr_a,
    input  logic [4:0]          i_rd_addr_b,
    input  logic [4:0]          i_dbg_addr,
    output logic [BUS_SIZE-1:0] o_rd_data_a,
    output logic [BUS_SIZE-1:0] o_rd_data_b,
    output logic [BUS_SIZE-1:0] o_dbg_data
);

    logic [BUS_SIZE-1:0] r_regs [REGS];
    logic                w_write;

    assign w_write = i_wr_en && (i_wr_addr != 5'd0);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_write) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    // Zero register first, then write-through bypass, then stored value.
    assign o_rd_data_a = (i_rd_addr_a == 5'd0)                   ? '0        :
                         (w_write && (i_wr_addr == i_rd_addr_a)) ? i_wr_data :
                                                                   r_regs[i_rd_addr_a];

    assign o_rd_data_b = (i_rd_addr_b == 5'd0)                   ? '0        :
                         (w_write && (i_wr_addr == i_rd_addr_b)) ? i_wr_data :
                                                                   r_regs[i_rd_addr_b];

    assign o_dbg_data  = (i_dbg_addr == 5'd0)                    ? '0        :
                         (w_write && (i_wr_addr == i_dbg_addr))  ? i_wr_data :
                                                                   r_regs[i_dbg_addr];

endmodule

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage
// Instruction-decode stage: splits the instruction into fields, builds the
// immediate extensions, reads rs/rt from the register bank, detects load-use
// and branch-operand hazards, resolves jumps/branches, and latches HALT.
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_enable              pipeline advance; low freezes register bank and halt
//   i_instruction, i_next_seq_pc    instruction and PC+4 from IF/ID
//   i_wb_en/addr/data     write-back port into the register bank
//   i_ex_mem_to_reg, i_ex_wb, i_ex_dst   instruction currently in EX
//   i_mem_wb, i_mem_dst                  instruction currently in MEM
//   i_dbg_addr, o_dbg_data               debug register read
//   o_bus_a/o_bus_b       rs/rt values
//   o_rs/rt/rd/funct/op   raw instruction fields
//   o_*_ext_*, o_inm_upp  immediate / shamt extensions
//   o_stall, o_jump, o_jump_addr, o_halt
// There is no handshake here: everything except the register bank and the
// halt flag is combinational on the current inputs, and i_enable alone
// decides whether the two pieces of state may change at the next edge.
// -----------------------------------------------------------------------------
module id_stage
    import id_stage_pkg::*;
#(
    parameter int BUS_SIZE = BUS_SIZE_DEF,
    parameter int REGS     = REGS_DEF
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic [31:0]         i_instruction,
    input  logic [BUS_SIZE-1:0] i_next_seq_pc,
    input  logic                i_wb_en,
    input  logic [4:0]          i_wb_addr,
    input  logic [BUS_SIZE-1:0] i_wb_data,
    input  logic                i_ex_mem_to_reg,
    input  logic                i_ex_wb,
    input  logic [4:0]          i_ex_dst,
    input  logic                i_mem_wb,
    input  logic [4:0]          i_mem_dst,
    input  logic [4:0]          i_dbg_addr,
    output logic [BUS_SIZE-1:0] o_dbg_data,
    output logic [BUS_SIZE-1:0] o_bus_a,
    output logic [BUS_SIZE-1:0] o_bus_b,
    output logic [4:0]          o_rs,
    output logic [4:0]          o_rt,
    output logic [4:0]          o_rd,
    output logic [5:0]          o_funct,
    output logic [5:0]          o_op,
    output logic [BUS_SIZE-1:0] o_shamt_ext_unsigned,
    output logic [BUS_SIZE-1:0] o_inm_ext_signed,
    output logic [BUS_SIZE-1:0] o_inm_upp,
    output logic [BUS_SIZE-1:0] o_inm_ext_unsigned,
    output logic [BUS_SIZE-1:0] o_next_seq_pc,
    output logic                o_stall,
    output logic                o_jump,
    output logic [BUS_SIZE-1:0] o_jump_addr,
    output logic                o_halt
);

    logic [5:0]          w_op;
    logic [5:0]          w_funct;
    logic [4:0]          w_rs;
    logic [4:0]          w_rt;
    logic [15:0]         w_imm;
    jump_kind_t          w_kind;
    logic                w_uses_rt;
    logic                w_ex_hit;
    logic                w_mem_hit;
    logic                w_load_use;
    logic                w_branch_hazard;
    logic [BUS_SIZE-1:0] w_branch_target;
    logic [BUS_SIZE-1:0] w_abs_target;
    logic                r_halt;

    // ------------------------------------------------------------------ fields
    assign w_op    = i_instruction[31:26];
    assign w_rs    = i_instruction[25:21];
    assign w_rt    = i_instruction[20:16];
    assign w_funct = i_instruction[5:0];
    assign w_imm   = i_instruction[15:0];

    assign o_op    = w_op;
    assign o_rs    = w_rs;
    assign o_rt    = w_rt;
    assign o_rd    = i_instruction[15:11];
    assign o_funct = w_funct;

    assign o_shamt_ext_unsigned = {{(BUS_SIZE-5){1'b0}}, i_instruction[10:6]};
    assign o_inm_ext_signed     = {{(BUS_SIZE-16){w_imm[15]}}, w_imm};
    assign o_inm_ext_unsigned   = {{(BUS_SIZE-16){1'b0}}, w_imm};
    assign o_inm_upp            = BUS_SIZE'({w_imm, 16'h0000});
    assign o_next_seq_pc        = i_next_seq_pc;

    // ----------------------------------------------------------- register bank
    // Write-back and its bypass are both gated by i_enable so a frozen
    // pipeline neither stores nor forwards the WB value.
    register_bank #(
        .BUS_SIZE (BUS_SIZE),
        .REGS     (REGS)
    ) u_register_bank (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_wr_en     (i_wb_en && i_enable),
        .i_wr_addr   (i_wb_addr),
        .i_wr_data   (i_wb_data),
        .i_rd_addr_a (w_rs),
        .i_rd_addr_b (w_rt),
        .i_dbg_addr  (i_dbg_addr),
        .o_rd_data_a (o_bus_a),
        .o_rd_data_b (o_bus_b),
        .o_dbg_data  (o_dbg_data)
    );

    // ----------------------------------------------------------------- hazards
    assign w_kind    = decode_jump_kind(w_op, w_funct);
    // JR/JALR only read rs; conditional branches compare rs with rt.
    assign w_uses_rt = (w_kind == JK_BEQ) || (w_kind == JK_BNE);

    assign w_ex_hit  = (i_ex_dst != 5'd0) &&
                       ((i_ex_dst == w_rs) || (w_uses_rt && (i_ex_dst == w_rt)));
    assign w_mem_hit = (i_mem_dst != 5'd0) &&
                       ((i_mem_dst == w_rs) || (w_uses_rt && (i_mem_dst == w_rt)));

    assign w_load_use = i_ex_mem_to_reg && (i_ex_dst != 5'd0) &&
                        ((i_ex_dst == w_rs) || (i_ex_dst == w_rt));

    // Branches resolve in ID, so any in-flight producer of an operand stalls.
    assign w_branch_hazard = (w_kind != JK_NONE) && (w_kind != JK_ABS) &&
                             ((i_ex_wb && w_ex_hit) || (i_mem_wb && w_mem_hit));

    assign o_stall = w_load_use || w_branch_hazard;

    // ------------------------------------------------------------- jump decode
    assign w_branch_target = i_next_seq_pc + (o_inm_ext_signed << 2);
    assign w_abs_target    = {i_next_seq_pc[BUS_SIZE-1:28], i_instruction[25:0], 2'b00};

    always_comb begin
        o_jump      = 1'b0;
        o_jump_addr = '0;
        if (!o_stall) begin
            case (w_kind)
                JK_ABS: begin
                    o_jump      = 1'b1;
                    o_jump_addr = w_abs_target;
                end
                JK_REG: begin
                    o_jump      = 1'b1;
                    o_jump_addr = o_bus_a;
                end
                JK_BEQ: begin
                    if (o_bus_a == o_bus_b) begin
                        o_jump      = 1'b1;
                        o_jump_addr = w_branch_target;
                    end
                end
                JK_BNE: begin
                    if (o_bus_a != o_bus_b) begin
                        o_jump      = 1'b1;
                        o_jump_addr = w_branch_target;
                    end
                end
                default: begin
                    o_jump      = 1'b0;
                    o_jump_addr = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------- halt flag
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_halt <= 1'b0;
        end else if (i_enable && (w_op == OP_HALT)) begin
            r_halt <= 1'b1;
        end
    end

    assign o_halt = r_halt;

endmodule
